// File: rtl/time_pkg.sv
// -----------------------------------------------------------------------------
// time_pkg
// Shared definitions for the time keeper slice.
//   ui_state_e : UI state encodings driven by the control layer
//   field_e    : edit-field selector codes
//   *_LSB/*_W  : field positions inside the packed 20-bit BCD time word
//                {h10[1:0], h1[3:0], m10[2:0], m1[3:0], s10[2:0], s1[3:0]}
//   inc_mod60 / inc_mod24 : BCD increment of a single field, wrapping at 59 / 23
//   norm_state : folds the unused state codes 5-7 onto IDLE
// -----------------------------------------------------------------------------
package time_pkg;

  localparam int TIME_W   = 20;
  localparam int SEC_LSB  = 0;
  localparam int SEC_W    = 7;
  localparam int MIN_LSB  = 7;
  localparam int MIN_W    = 7;
  localparam int HOUR_LSB = 14;
  localparam int HOUR_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_ALARM  = 3'd2,
    ST_COUNT  = 3'd3,
    ST_SELECT = 3'd4
  } ui_state_e;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2
  } field_e;

  // {tens[2:0], ones[3:0]}, 00..59
  function automatic logic [6:0] inc_mod60(input logic [6:0] v);
    logic [2:0] tens;
    logic [3:0] ones;
    tens = v[6:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 3'd5) ? 3'd0 : tens + 3'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // {tens[1:0], ones[3:0]}, 00..23
  function automatic logic [5:0] inc_mod24(input logic [5:0] v);
    logic [1:0] tens;
    logic [3:0] ones;
    tens = v[5:4];
    ones = v[3:0];
    if (v == 6'h23) begin
      tens = 2'd0;
      ones = 4'd0;
    end else if (ones == 4'd9) begin
      ones = 4'd0;
      tens = tens + 2'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  function automatic ui_state_e norm_state(input logic [2:0] s);
    if (s > 3'd4) return ST_IDLE;
    return ui_state_e'(s);
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// -----------------------------------------------------------------------------
// time_keeper_if
// Bundle between the UI control layer and the time keeper.
//   master (control / display side): drives state and button pulses,
//                                    reads time_data and status
//   slave  (time_keeper)           : the reverse
// Signals:
//   state[2:0]      UI state code
//   btn_next/inc/confirm/clr  one-cycle, debounced button pulses
//   time_data[19:0] packed BCD time for the seven-segment driver
//   has_alarm       alarm armed
//   alarm_ring      alarm firing
//   sel_field[1:0]  current edit field
//   sec_tick        one-cycle pulse per second
// -----------------------------------------------------------------------------
interface time_keeper_if;
  import time_pkg::*;

  logic [2:0]        state;
  logic              btn_next;
  logic              btn_inc;
  logic              btn_confirm;
  logic              btn_clr;
  logic [TIME_W-1:0] time_data;
  logic              has_alarm;
  logic              alarm_ring;
  logic [1:0]        sel_field;
  logic              sec_tick;

  modport master (
    output state, btn_next, btn_inc, btn_confirm, btn_clr,
    input  time_data, has_alarm, alarm_ring, sel_field, sec_tick
  );

  modport slave (
    input  state, btn_next, btn_inc, btn_confirm, btn_clr,
    output time_data, has_alarm, alarm_ring, sel_field, sec_tick
  );

endinterface

// File: rtl/bcd_time_step.sv
// -----------------------------------------------------------------------------
// bcd_time_step
// Combinational +1 second on a packed BCD time word, carrying seconds into
// minutes into hours; 23:59:59 wraps to 00:00:00.
//   t_i : current time (legal BCD)
//   t_o : time plus one second
// -----------------------------------------------------------------------------
module bcd_time_step
  import time_pkg::*;
(
  input  logic [TIME_W-1:0] t_i,
  output logic [TIME_W-1:0] t_o
);

  logic sec_wrap;
  logic min_wrap;

  always_comb begin
    sec_wrap = (t_i[SEC_LSB +: SEC_W] == 7'h59);
    min_wrap = (t_i[MIN_LSB +: MIN_W] == 7'h59);

    t_o[SEC_LSB +: SEC_W] = inc_mod60(t_i[SEC_LSB +: SEC_W]);
    t_o[MIN_LSB +: MIN_W] = sec_wrap ? inc_mod60(t_i[MIN_LSB +: MIN_W])
                                     : t_i[MIN_LSB +: MIN_W];
    t_o[HOUR_LSB +: HOUR_W] = (sec_wrap && min_wrap) ? inc_mod24(t_i[HOUR_LSB +: HOUR_W])
                                                     : t_i[HOUR_LSB +: HOUR_W];
  end

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// BCD time source for the seven-segment driver. Keeps a real-time clock, an
// edit buffer (SET/ALARM), an alarm register and a stopwatch, and shows one
// of them depending on the UI state.
// Ports:
//   led_clk : scan-rate clock, all state on its rising edge
//   rstn    : asynchronous active-low reset
//   bus     : time_keeper_if.slave (state, buttons in; time/status out)
// Parameter:
//   TICKS_PER_SEC : led_clk cycles per second (>= 2)
// -----------------------------------------------------------------------------
module time_keeper
  import time_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic          led_clk,
  input  logic          rstn,
  time_keeper_if.slave  bus
);

  localparam int            PW   = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [TIME_W-1:0] rtc_q, rtc_d;
  logic [TIME_W-1:0] edit_q, edit_d;
  logic [TIME_W-1:0] alm_q, alm_d;
  logic [TIME_W-1:0] sw_q, sw_d;
  logic              run_q, run_d;
  logic              has_q, has_d;
  logic              ring_q, ring_d;
  field_e            sel_q, sel_d;
  ui_state_e         prev_q, prev_d;
  logic [TIME_W-1:0] td_q, td_d;

  logic [TIME_W-1:0] rtc_step, sw_step;
  logic [TIME_W-1:0] edit_inc, edit_clr;
  field_e            sel_adv;
  logic              hour_zero;

  ui_state_e st;
  logic      entry;
  logic      act_clr, act_conf, act_inc, act_next;
  logic      set_conf;

  bcd_time_step u_rtc_step (.t_i(rtc_q), .t_o(rtc_step));
  bcd_time_step u_sw_step  (.t_i(sw_q),  .t_o(sw_step));

  // Buttons are ignored on the entry cycle; otherwise only the highest
  // priority pulse (clr > confirm > inc > next) is acted on.
  assign st       = norm_state(bus.state);
  assign entry    = (st != prev_q);
  assign act_clr  = !entry && bus.btn_clr;
  assign act_conf = !entry && !bus.btn_clr && bus.btn_confirm;
  assign act_inc  = !entry && !bus.btn_clr && !bus.btn_confirm && bus.btn_inc;
  assign act_next = !entry && !bus.btn_clr && !bus.btn_confirm && !bus.btn_inc && bus.btn_next;
  assign set_conf = act_conf && (st == ST_SET);

  // Per-field edit results; no carry between fields.
  always_comb begin
    edit_inc  = edit_q;
    edit_clr  = edit_q;
    hour_zero = (edit_q[HOUR_LSB +: HOUR_W] == '0);
    case (sel_q)
      FLD_SEC: begin
        edit_inc[SEC_LSB +: SEC_W] = inc_mod60(edit_q[SEC_LSB +: SEC_W]);
        edit_clr[SEC_LSB +: SEC_W] = '0;
      end
      FLD_MIN: begin
        edit_inc[MIN_LSB +: MIN_W] = inc_mod60(edit_q[MIN_LSB +: MIN_W]);
        edit_clr[MIN_LSB +: MIN_W] = '0;
      end
      default: begin
        edit_inc[HOUR_LSB +: HOUR_W] = inc_mod24(edit_q[HOUR_LSB +: HOUR_W]);
        edit_clr[HOUR_LSB +: HOUR_W] = '0;
      end
    endcase
  end

  always_comb begin
    case (sel_q)
      FLD_SEC: sel_adv = FLD_MIN;
      FLD_MIN: sel_adv = FLD_HOUR;
      default: sel_adv = FLD_SEC;
    endcase
  end

  always_comb begin
    presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_q == PMAX);
    rtc_d   = tick_q ? rtc_step : rtc_q;
    sw_d    = (run_q && tick_q) ? sw_step : sw_q;
    edit_d  = edit_q;
    alm_d   = alm_q;
    has_d   = has_q;
    run_d   = run_q;
    sel_d   = sel_q;
    prev_d  = st;

    if (entry && (st == ST_SET)) begin
      edit_d = rtc_q;
      sel_d  = FLD_SEC;
    end else if (entry && (st == ST_ALARM)) begin
      edit_d = has_q ? alm_q : '0;
      sel_d  = FLD_SEC;
    end

    case (st)
      ST_SET, ST_ALARM: begin
        if (act_clr) begin
          edit_d = edit_clr;
          // Clearing an already-zero hour field in ALARM disarms the alarm.
          if ((st == ST_ALARM) && (sel_q == FLD_HOUR) && hour_zero) has_d = 1'b0;
        end else if (act_conf) begin
          if (st == ST_SET) begin
            // Commit wins over a pending tick; the second restarts here.
            rtc_d   = edit_q;
            presc_d = '0;
            tick_d  = 1'b0;
          end else begin
            alm_d = edit_q;
            has_d = 1'b1;
          end
        end else if (act_inc) begin
          edit_d = edit_inc;
        end else if (act_next) begin
          sel_d = sel_adv;
        end
      end
      ST_COUNT: begin
        if (act_clr) begin
          sw_d  = '0;
          run_d = 1'b0;
        end else if (act_conf) begin
          run_d = !run_q;
        end
      end
      default: begin
      end
    endcase

    // Ring is raised together with the clock update that hits the alarm
    // time, so it is visible in the cycle after the tick.
    ring_d = ring_q;
    if (bus.btn_clr || bus.btn_confirm || !has_d) ring_d = 1'b0;
    else if (tick_q && !set_conf && has_q && (rtc_step == alm_q)) ring_d = 1'b1;

    case (st)
      ST_SET, ST_ALARM: td_d = edit_q;
      ST_COUNT:         td_d = sw_q;
      default:          td_d = rtc_q;
    endcase
  end

  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      rtc_q   <= '0;
      edit_q  <= '0;
      alm_q   <= '0;
      sw_q    <= '0;
      run_q   <= 1'b0;
      has_q   <= 1'b0;
      ring_q  <= 1'b0;
      sel_q   <= FLD_SEC;
      prev_q  <= ST_IDLE;
      td_q    <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      rtc_q   <= rtc_d;
      edit_q  <= edit_d;
      alm_q   <= alm_d;
      sw_q    <= sw_d;
      run_q   <= run_d;
      has_q   <= has_d;
      ring_q  <= ring_d;
      sel_q   <= sel_d;
      prev_q  <= prev_d;
      td_q    <= td_d;
    end
  end

  assign bus.time_data  = td_q;
  assign bus.has_alarm  = has_q;
  assign bus.alarm_ring = ring_q;
  assign bus.sel_field  = sel_q;
  assign bus.sec_tick   = tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_time_keeper
// Directed bench for time_keeper with TICKS_PER_SEC = 4: a vector table for
// the SET edit operations plus hand-written sequences for tick timing, clock
// load/wrap, alarm, stopwatch and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_time_keeper;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_NEXT = 4'b0001;
  localparam logic [3:0] B_INC  = 4'b0010;
  localparam logic [3:0] B_CONF = 4'b0100;
  localparam logic [3:0] B_CLR  = 4'b1000;

  typedef struct {
    logic [3:0]  btn;   // {clr, confirm, inc, next}
    logic [19:0] td;
    logic [1:0]  sel;
  } vec_t;

  logic led_clk;
  logic rstn;
  int   errs;
  int   checks;
  vec_t tbl[10];

  time_keeper_if bus();

  time_keeper #(.TICKS_PER_SEC(4)) dut (
    .led_clk (led_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge led_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] b);
    bus.btn_clr     = b[3];
    bus.btn_confirm = b[2];
    bus.btn_inc     = b[1];
    bus.btn_next    = b[0];
    step(1);
    bus.btn_clr     = 1'b0;
    bus.btn_confirm = 1'b0;
    bus.btn_inc     = 1'b0;
    bus.btn_next    = 1'b0;
  endtask

  task automatic press_n(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.sec_tick && n < 20);
    checks++;
    if (!bus.sec_tick) begin
      errs++;
      $display("FAIL wait_tick: sec_tick not seen within 20 cycles");
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    tbl[0] = '{B_INC,          20'h00001, 2'd0};
    tbl[1] = '{B_INC | B_NEXT, 20'h00002, 2'd0};
    tbl[2] = '{B_NEXT,         20'h00002, 2'd1};
    tbl[3] = '{B_INC,          20'h00082, 2'd1};
    tbl[4] = '{B_CLR,          20'h00002, 2'd1};
    tbl[5] = '{B_NEXT,         20'h00002, 2'd2};
    tbl[6] = '{B_INC,          20'h04002, 2'd2};
    tbl[7] = '{B_CLR | B_INC,  20'h00002, 2'd2};
    tbl[8] = '{B_NEXT,         20'h00002, 2'd0};
    tbl[9] = '{B_CLR | B_NEXT, 20'h00000, 2'd0};

    rstn            = 1'b0;
    bus.state       = 3'd0;
    bus.btn_next    = 1'b0;
    bus.btn_inc     = 1'b0;
    bus.btn_confirm = 1'b0;
    bus.btn_clr     = 1'b0;

    // Reset state
    step(3);
    chk("rst_time_data", bus.time_data, 20'h0);
    chk("rst_has_alarm", bus.has_alarm, 0);
    chk("rst_alarm_ring", bus.alarm_ring, 0);
    chk("rst_sel_field", bus.sel_field, 0);
    chk("rst_sec_tick", bus.sec_tick, 0);

    // First second and ten-second roll in IDLE
    rstn = 1'b1;
    step(4);
    chk("first_tick", bus.sec_tick, 1);
    chk("first_tick_td", bus.time_data, 20'h0);
    step(1);
    chk("tick_one_cycle", bus.sec_tick, 0);
    chk("td_lag", bus.time_data, 20'h0);
    step(1);
    chk("td_1s", bus.time_data, 20'h00001);
    step(35);
    chk("td_9s", bus.time_data, 20'h00009);
    step(1);
    chk("td_10s", bus.time_data, 20'h00010);

    // SET: hour field +25 -> 01, confirm loses the pending tick
    bus.state = 3'd1;
    do_reset();
    step(1);
    press(B_NEXT);
    press(B_NEXT);
    chk("set_sel_hour", bus.sel_field, 2);
    press_n(B_INC, 25);
    press(B_CONF);
    chk("set_edit_01h", bus.time_data, 20'h04000);
    bus.state = 3'd0;
    step(1);
    chk("set_clock_01h", bus.time_data, 20'h04000);
    step(2);
    chk("presc_restart_no_tick", bus.sec_tick, 0);
    step(1);
    chk("presc_restart_tick", bus.sec_tick, 1);
    step(2);
    chk("set_clock_01h_1s", bus.time_data, 20'h04001);

    // SET edit vectors
    bus.state = 3'd1;
    do_reset();
    step(1);
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].btn);
      step(1);
      chk($sformatf("vec%0d_td", i), bus.time_data, tbl[i].td);
      chk($sformatf("vec%0d_sel", i), bus.sel_field, tbl[i].sel);
    end

    // Field boundaries
    press_n(B_INC, 37);
    step(1);
    chk("sec_37", bus.time_data, 20'h00037);
    press(B_CLR | B_INC);
    step(1);
    chk("clr_beats_inc", bus.time_data, 20'h00000);
    press_n(B_INC, 59);
    step(1);
    chk("sec_59", bus.time_data, 20'h00059);
    press(B_INC);
    step(1);
    chk("sec_wrap_no_carry", bus.time_data, 20'h00000);
    press_n(B_INC, 59);
    press(B_NEXT);
    press_n(B_INC, 59);
    step(1);
    chk("edit_00_59_59", bus.time_data, 20'h02CD9);
    press(B_NEXT);
    press_n(B_INC, 23);
    step(1);
    chk("edit_23_59_59", bus.time_data, 20'h8ECD9);
    press(B_INC);
    step(1);
    chk("hour_wrap_no_carry", bus.time_data, 20'h02CD9);
    press_n(B_INC, 23);

    // Load 23:59:59, one tick wraps to midnight
    press(B_CONF);
    bus.state = 3'd0;
    step(1);
    chk("clock_23_59_59", bus.time_data, 20'h8ECD9);
    step(3);
    chk("wrap_tick", bus.sec_tick, 1);
    step(1);
    chk("wrap_td_lag", bus.time_data, 20'h8ECD9);
    step(1);
    chk("wrap_midnight", bus.time_data, 20'h00000);

    // ALARM at 00:00:05
    bus.state = 3'd2;
    do_reset();
    step(1);
    press_n(B_INC, 5);
    press(B_CONF);
    chk("alarm_armed", bus.has_alarm, 1);
    bus.state = 3'd0;
    step(13);
    chk("ring_before", bus.alarm_ring, 0);
    step(1);
    chk("ring_rise", bus.alarm_ring, 1);
    step(1);
    chk("ring_td_5s", bus.time_data, 20'h00005);
    press(B_CLR);
    chk("ring_clr", bus.alarm_ring, 0);
    chk("ring_clr_keeps_armed", bus.has_alarm, 1);

    // Re-enter ALARM: edit shows stored alarm; clear zero hour disarms
    bus.state = 3'd5;
    step(1);
    bus.state = 3'd2;
    step(2);
    chk("alarm_reload", bus.time_data, 20'h00005);
    press(B_NEXT);
    press(B_NEXT);
    press(B_INC);
    press(B_CLR);
    chk("clr_nonzero_hour_armed", bus.has_alarm, 1);
    press(B_CLR);
    chk("clr_zero_hour_disarm", bus.has_alarm, 0);

    // Stopwatch: run 3 s, stop, wait 2 s, clear
    bus.state = 3'd3;
    step(1);
    wait_tick();
    press(B_CONF);
    wait_tick();
    wait_tick();
    wait_tick();
    press(B_CONF);
    wait_tick();
    wait_tick();
    step(1);
    chk("sw_3s", bus.time_data, 20'h00003);
    press(B_CLR);
    step(1);
    chk("sw_clr", bus.time_data, 20'h00000);

    // Asynchronous reset mid-COUNT
    wait_tick();
    press(B_CONF);
    wait_tick();
    wait_tick();
    step(2);
    chk("sw_2s", bus.time_data, 20'h00002);
    chk("sel_before_rst", bus.sel_field, 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_td", bus.time_data, 20'h0);
    chk("async_rst_sel", bus.sel_field, 0);
    chk("async_rst_has", bus.has_alarm, 0);
    chk("async_rst_ring", bus.alarm_ring, 0);
    chk("async_rst_tick", bus.sec_tick, 0);
    step(2);
    rstn = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
